// File: rtl/pattern_detector_pkg.sv
// Shared defaults for the serial pattern detector and its match counter.
package pattern_detector_pkg;
    localparam int          PAT_W_DEF     = 4;
    localparam int          CNT_W_DEF     = 8;
    localparam logic [15:0] RESET_PAT_DEF = 16'b1101;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == '1) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end
endmodule

// File: rtl/pattern_detector.sv
// Serial Mealy pattern detector with loadable pattern, overlap control and
// a saturating match counter.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int             PAT_W     = PAT_W_DEF,
    parameter int             CNT_W     = CNT_W_DEF,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(RESET_PAT_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  window;
    logic              z_p0;
    logic              z_p1;

    // Stage 0: combinational match on the window completed by the current bit
    always_comb begin
        window = {hist, x};
        z_p0   = ~reset & x_valid & ~pat_load & (fill == FILL_MAX) & (window == pattern);
    end

    assign z = z_p0;

    // Stage 1: history, fill level, pattern and registered match
    always_ff @(posedge clk) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= RESET_PAT;
            z_p1    <= 1'b0;
        end else begin
            z_p1 <= z_p0;
            if (pat_load) begin
                pattern <= pat_in;
                fill    <= '0;
            end else if (x_valid) begin
                hist <= window[PAT_W-2:0];
                // Non-overlapping mode restarts the fill so a new match needs PAT_W fresh bits
                if (z_p0 && !overlap) begin
                    fill <= '0;
                end else if (fill != FILL_MAX) begin
                    fill <= fill + FILL_W'(1);
                end
            end
        end
    end

    assign z_q = z_p1;

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (z_p0),
        .cnt  (match_cnt)
    );
endmodule

// File: tb/tb_pattern_detector.sv
// Directed bench for pattern_detector: default (CNT_W=8) and narrow (CNT_W=2) counters.
module tb_pattern_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       overlap = 1'b1;
    logic       cnt_clr = 1'b0;

    logic       z_a, z_q_a;
    logic [7:0] cnt_a;
    logic       z_b, z_q_b;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];
    logic zq_exp = 1'b0;
    bit   first = 1'b1;

    always #5 clk = ~clk;

    pattern_detector dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
        .z(z_a), .z_q(z_q_a), .match_cnt(cnt_a)
    );

    pattern_detector #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr),
        .z(z_b), .z_q(z_q_b), .match_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One cycle of stimulus: drive after negedge, check Mealy z before the next posedge
    task automatic step(input string tag, input logic xv, input logic xb, input logic pl,
                        input logic [3:0] pin, input logic clr, input logic rs,
                        input logic exp_z);
        logic e;
        @(negedge clk);
        x = xb; x_valid = xv; pat_load = pl; pat_in = pin; cnt_clr = clr; reset = rs;
        exp_q.push_back(exp_z);
        #2;
        e = exp_q.pop_front();
        check({tag, ".z"}, {7'd0, z_a}, {7'd0, e});
        check({tag, ".z_b"}, {7'd0, z_b}, {7'd0, e});
        if (!first) check({tag, ".z_q"}, {7'd0, z_q_a}, {7'd0, zq_exp});
        first = 1'b0;
        zq_exp = e;
    endtask

    task automatic bit_in(input string tag, input logic b, input logic exp_z);
        step(tag, 1'b1, b, 1'b0, 4'b0000, 1'b0, 1'b0, exp_z);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step("rst", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        step("rst", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic s [7];
        s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        idle("post_rst");
        check("rst.cnt_a", cnt_a, 8'd0);
        check("rst.cnt_b", {6'd0, cnt_b}, 8'd0);
        check("rst.z_q", {7'd0, z_q_a}, 8'd0);

        // Overlapping detection of 1101 in 1101101
        overlap = 1'b1;
        for (int i = 0; i < 7; i++) bit_in("ovl", s[i], (i == 3 || i == 6));
        idle("ovl_end");
        check("ovl.cnt", cnt_a, 8'd2);

        // Non-overlapping: second match needs fresh bits
        do_reset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++) bit_in("novl", s[i], (i == 3));
        idle("novl_end");
        check("novl.cnt", cnt_a, 8'd1);

        // Gap of invalid cycles holds history; x toggles during the gap
        do_reset();
        overlap = 1'b1;
        bit_in("gap", 1'b1, 1'b0);
        bit_in("gap", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, i[0], 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        bit_in("gap", 1'b0, 1'b0);
        bit_in("gap", 1'b1, 1'b1);
        idle("gap_end");
        check("gap.cnt", cnt_a, 8'd1);

        // Pattern load mid-stream; the simultaneous valid bit is discarded
        do_reset();
        bit_in("load", 1'b1, 1'b0);
        bit_in("load", 1'b1, 1'b0);
        step("load_cyc", 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        bit_in("load", 1'b0, 1'b0);
        bit_in("load", 1'b1, 1'b0);
        bit_in("load", 1'b1, 1'b0);
        bit_in("load", 1'b0, 1'b1);
        idle("load_end");
        check("load.cnt", cnt_a, 8'd1);

        // Saturation of the 2-bit counter after 5 matches, then clear on a match cycle
        do_reset();
        overlap = 1'b1;
        bit_in("sat", 1'b1, 1'b0);
        bit_in("sat", 1'b1, 1'b0);
        bit_in("sat", 1'b0, 1'b0);
        bit_in("sat", 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bit_in("sat", 1'b1, 1'b0);
            bit_in("sat", 1'b0, 1'b0);
            bit_in("sat", 1'b1, 1'b1);
        end
        idle("sat_end");
        check("sat.cnt_b", {6'd0, cnt_b}, 8'd3);
        check("sat.cnt_a", cnt_a, 8'd5);
        bit_in("clr", 1'b1, 1'b0);
        bit_in("clr", 1'b0, 1'b0);
        step("clr_match", 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        idle("clr_end");
        check("clr.cnt_b", {6'd0, cnt_b}, 8'd0);
        check("clr.cnt_a", cnt_a, 8'd0);
        bit_in("clr_after", 1'b1, 1'b0);
        bit_in("clr_after", 1'b0, 1'b0);
        bit_in("clr_after", 1'b1, 1'b1);
        idle("clr_after_end");
        check("clr_after.cnt_b", {6'd0, cnt_b}, 8'd1);

        // Reset mid-sequence discards the partial match; controls ignored during reset
        do_reset();
        bit_in("mid", 1'b1, 1'b0);
        bit_in("mid", 1'b1, 1'b0);
        bit_in("mid", 1'b0, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0);
        bit_in("mid", 1'b1, 1'b0);
        bit_in("mid", 1'b1, 1'b0);
        bit_in("mid", 1'b1, 1'b0);
        bit_in("mid", 1'b0, 1'b0);
        bit_in("mid", 1'b1, 1'b1);
        idle("mid_end");
        check("mid.cnt", cnt_a, 8'd1);
        check("mid.z_q_b", {7'd0, z_q_b}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match counter width.
REQ-003 The block SHALL have parameter RESET_PAT, default 4'b1101 zero-extended to PAT_W, giving the pattern loaded at reset.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port x_valid, input, 1 bit: x is accepted this cycle.
REQ-008 The block SHALL have port pat_load, input, 1 bit: load pat_in as the new pattern.
REQ-009 The block SHALL have port pat_in, input, PAT_W bits: new pattern; bit PAT_W-1 is the first bit received.
REQ-010 The block SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: clear the match counter.
REQ-012 The block SHALL have port z, output, 1 bit: Mealy match, combinational, same cycle as the completing bit.
REQ-013 The block SHALL have port z_q, output, 1 bit: registered copy of z, one cycle later.
REQ-014 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-015 The block SHALL keep a history register hist of PAT_W-1 bits; each accepted bit shifts in at the LSB.
REQ-016 The block SHALL keep a fill counter, 0..PAT_W-1, that increments per accepted bit and saturates at PAT_W-1.
REQ-017 The block SHALL compute window = {hist, x}.
REQ-018 The block SHALL assert z = x_valid & ~pat_load & (fill == PAT_W-1) & (window == pattern).
REQ-019 When x_valid=0, the block SHALL hold hist and fill unchanged and drive z=0.
REQ-020 On a match with overlap=1, the block SHALL shift hist normally and leave fill saturated, so suffix/prefix overlaps detect.
REQ-021 On a match with overlap=0, the block SHALL shift hist and reset fill to 0, so the next match needs PAT_W fresh bits.
REQ-022 When pat_load=1, the block SHALL set pattern to pat_in and fill to 0, discard any simultaneous x_valid bit, and drive z=0.
REQ-023 The block SHALL sample overlap on every cycle; a change takes effect on the next accepted bit.
REQ-024 On each z=1 cycle, the block SHALL increment match_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 When cnt_clr=1, the block SHALL set match_cnt to 0; this has priority over a simultaneous match.
REQ-026 The block SHALL register z_q as z_q <= z, for latency 1.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL set hist=0, fill=0, pattern=RESET_PAT, z_q=0 and match_cnt=0.
REQ-028 While reset=1, the block SHALL force z=0 and ignore x_valid, pat_load and cnt_clr.
REQ-029 Reset asserted mid-sequence SHALL discard any partial match; after release, detection SHALL require PAT_W new bits.

Structure
REQ-030 The shared package pattern_detector_pkg SHALL hold the default PAT_W, CNT_W and RESET_PAT constants.
REQ-031 The match counter SHALL be the sub-module sat_counter (parameter W, ports clk, reset, clr, inc, cnt).
REQ-032 All sequential logic SHALL be in clk-edge processes with synchronous reset; there SHALL be no latches.

Verification
REQ-033 The bench SHALL apply reset, default pattern 1101, overlap=1, stream 1,1,0,1,1,0,1 and check z=1 on bits 4 and 7, with match_cnt=2.
REQ-034 The bench SHALL apply the same stream with overlap=0 and check z=1 on bit 4 only, with match_cnt=1.
REQ-035 The bench SHALL apply stream 1,1,(x_valid=0 for 3 cycles),0,1 and check z=1 on the final bit, with z=0 during the gap.
REQ-036 The bench SHALL load pat_in=0110 after bits 1,1 of a 1101 stream, then send 0,1,1,0, and check z=1 only on the 4th bit after the load.
REQ-037 The bench SHALL set CNT_W=2, force 5 matches, and check match_cnt=3; it SHALL then pulse cnt_clr on a match cycle and check match_cnt=0.
REQ-038 The bench SHALL assert reset after bits 1,1,0, then send 1 and check z=0; it SHALL then send 1,1,0,1 and check z=1 on the last bit.
